// File: rtl/reversi_accel_sdiv_seq_28s_12s_16_if.sv
// Handshake/bus bundle for the iterative signed divider.
// master: drives ce, start, din0, din1; observes busy, done, dout, rem, div0, ovf.
// slave : the divider side of the same signals.
interface reversi_accel_sdiv_seq_28s_12s_16_if #(
  parameter int unsigned din0_WIDTH = 28,
  parameter int unsigned din1_WIDTH = 12,
  parameter int unsigned dout_WIDTH = 16
);
  logic                          ce;
  logic                          start;
  logic signed [din0_WIDTH-1:0]  din0;
  logic signed [din1_WIDTH-1:0]  din1;
  logic                          busy;
  logic                          done;
  logic signed [dout_WIDTH-1:0]  dout;
  logic signed [din1_WIDTH-1:0]  rem;
  logic                          div0;
  logic                          ovf;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout, rem, div0, ovf
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout, rem, div0, ovf
  );
endinterface

// File: rtl/reversi_accel_sdiv_seq_28s_12s_16.sv
// Iterative restoring signed divider, one quotient bit per ce cycle.
// Quotient truncates toward zero and saturates to dout_WIDTH; remainder
// follows the dividend's sign. Optional macro REVERSI_DIV_ROUND_EN switches
// the quotient to round-half-away-from-zero.
// Ports: clk, reset (sync, active-high), bus (slave modport: ce, start,
// din0, din1 in; busy, done, dout, rem, div0, ovf out).
module reversi_accel_sdiv_seq_28s_12s_16 #(
  parameter int unsigned din0_WIDTH = 28,
  parameter int unsigned din1_WIDTH = 12,
  parameter int unsigned dout_WIDTH = 16
) (
  input logic                                clk,
  input logic                                reset,
  reversi_accel_sdiv_seq_28s_12s_16_if.slave bus
);

  localparam int unsigned N0    = din0_WIDTH;
  localparam int unsigned N1    = din1_WIDTH;
  localparam int unsigned NO    = dout_WIDTH;
  localparam int unsigned CNT_W = $clog2(din0_WIDTH);
  localparam int unsigned POS_LIM = (2 ** (NO - 1)) - 1;
  localparam int unsigned NEG_LIM = 2 ** (NO - 1);
  localparam logic [NO-1:0] DOUT_MAX = {1'b0, {(NO-1){1'b1}}};
  localparam logic [NO-1:0] DOUT_MIN = {1'b1, {(NO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N0-1:0]     dvd_q, dvd_d;   // dividend magnitude in, quotient shifts in at LSB
  logic [N1-1:0]     pr_q, pr_d;     // partial remainder, always < |divisor|
  logic [N1-1:0]     dsr_q, dsr_d;   // divisor magnitude
  logic              s0_q, s0_d;
  logic              s1_q, s1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NO-1:0]     dout_q, dout_d;
  logic [N1-1:0]     rem_q, rem_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;

  logic [N1:0]       pr_sh;
  logic [N1:0]       pr_sub;
  logic              qbit;
  logic [N0-1:0]     qmag;
  logic [N1-1:0]     rmag;
  logic              rneg;
  logic              qneg;

  // State register; ce gating is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      pr_q    <= '0;
      dsr_q   <= '0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      pr_q    <= pr_d;
      dsr_q   <= dsr_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, restoring step and sign/saturation fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    pr_d    = pr_q;
    dsr_d   = dsr_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;

    pr_sh  = {pr_q, dvd_q[N0-1]};
    pr_sub = pr_sh - {1'b0, dsr_q};
    qbit   = (pr_sh >= {1'b0, dsr_q});
    qmag   = dvd_q;
    rmag   = pr_q;
    rneg   = s0_q;
`ifdef REVERSI_DIV_ROUND_EN
    // Round half away from zero: bump magnitude, remainder flips side.
    if ({pr_q, 1'b0} >= {1'b0, dsr_q}) begin
      qmag = dvd_q + N0'(1);
      rmag = dsr_q - pr_q;
      rneg = ~s0_q;
    end
`endif
    qneg = (s0_q ^ s1_q) && (qmag != '0);

    if (bus.ce) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (bus.start) begin
            // Two's-complement negate of the most-negative value still yields
            // the correct unsigned magnitude in the same width.
            dvd_d  = bus.din0[N0-1] ? N0'(~$unsigned(bus.din0) + N0'(1)) : N0'($unsigned(bus.din0));
            dsr_d  = bus.din1[N1-1] ? N1'(~$unsigned(bus.din1) + N1'(1)) : N1'($unsigned(bus.din1));
            s0_d   = bus.din0[N0-1];
            s1_d   = bus.din1[N1-1];
            pr_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            div0_d = 1'b0;
            ovf_d  = 1'b0;
            state_d = CALC;
          end
        end
        CALC: begin
          if (dsr_q == '0) begin
            state_d = FIX;
          end else begin
            pr_d  = qbit ? pr_sub[N1-1:0] : pr_sh[N1-1:0];
            dvd_d = {dvd_q[N0-2:0], qbit};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N0 - 1)) begin
              state_d = FIX;
            end
          end
        end
        FIX: begin
          if (dsr_q == '0) begin
            dout_d = s0_q ? DOUT_MIN : DOUT_MAX;
            rem_d  = '0;
            div0_d = 1'b1;
            ovf_d  = 1'b0;
          end else begin
            rem_d = rneg ? N1'(~rmag + N1'(1)) : rmag;
            ovf_d = 1'b0;
            if (qneg) begin
              if (qmag > N0'(NEG_LIM)) begin
                dout_d = DOUT_MIN;
                ovf_d  = 1'b1;
              end else begin
                dout_d = NO'(~qmag + N0'(1));
              end
            end else begin
              if (qmag > N0'(POS_LIM)) begin
                dout_d = DOUT_MAX;
                ovf_d  = 1'b1;
              end else begin
                dout_d = NO'(qmag);
              end
            end
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = $signed(dout_q);
  assign bus.rem  = $signed(rem_q);
  assign bus.div0 = div0_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_reversi_accel_sdiv_seq_28s_12s_16.sv
// Self-checking bench for the iterative signed divider: directed corner
// cases plus randomized operands against an arithmetic reference model.
module tb_reversi_accel_sdiv_seq_28s_12s_16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  reversi_accel_sdiv_seq_28s_12s_16_if bus ();

  reversi_accel_sdiv_seq_28s_12s_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, then optional rounding and saturation.
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r,
                                output logic d0, output logic ov);
    longint ar, br;
    d0 = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = (a >= 0) ? 32767 : -32768;
      r  = 0;
      d0 = 1'b1;
      return;
    end
    q = a / b;
    r = a % b;
`ifdef REVERSI_DIV_ROUND_EN
    ar = (r < 0) ? -r : r;
    br = (b < 0) ? -b : b;
    if (2 * ar >= br) begin
      q = q + (((a < 0) != (b < 0)) ? -1 : 1);
      r = a - q * b;
    end
`else
    ar = 0;
    br = 0;
`endif
    if (q > 32767) begin
      q  = 32767;
      ov = 1'b1;
    end else if (q < -32768) begin
      q  = -32768;
      ov = 1'b1;
    end
  endfunction

  // Caller is at a negedge; start is driven immediately so back-to-back
  // calls exercise acceptance on the done cycle. Returns at the negedge
  // where done is high (or at the cycle budget).
  task automatic run_div(input string tag, input longint a, input longint b,
                         input int stall_at, input int stall_len, input int junk_at);
    longint q, r;
    logic   d0, ov;
    int     k;
    int     lat;
    model(a, b, q, r, d0, ov);
    lat = ((b == 0) ? 2 : 29) + stall_len;
    bus.ce    = 1'b1;
    bus.start = 1'b1;
    bus.din0  = 28'(a);
    bus.din1  = 12'(b);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy_after_accept"}, 64'(bus.busy), 1);
    check({tag, "_done_low_after_accept"}, 64'(bus.done), 0);
    k = 0;
    while (bus.done !== 1'b1 && k < 200) begin
      if (k == stall_at) bus.ce = 1'b0;
      if (k == stall_at + stall_len) bus.ce = 1'b1;
      if (k == junk_at) begin
        bus.start = 1'b1;
        bus.din0  = 28'sd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_dout"}, 64'(bus.dout), q);
    check({tag, "_rem"}, 64'(bus.rem), r);
    check({tag, "_div0"}, 64'(bus.div0), 64'(d0));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(ov));
  endtask

  initial begin
    int n_done;
    logic signed [27:0] ra;
    logic signed [19:0] rs;
    logic signed [11:0] rb;
    logic signed [3:0]  rbs;
    longint a, b;
    logic signed [15:0] held;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_dout", 64'(bus.dout), 0);
    check("rst_rem",  64'(bus.rem),  0);
    check("rst_div0", 64'(bus.div0), 0);
    check("rst_ovf",  64'(bus.ovf),  0);
    reset = 1'b0;
    @(negedge clk);

    // Directed set, issued back to back.
    run_div("pos",     1000, 7, -1, 0, -1);
    run_div("negdvd",  -1000, 7, -1, 0, -1);
    run_div("negdsr",  1000, -7, -1, 0, -1);
    run_div("half",    11, 2, -1, 0, -1);
    run_div("dz_pos",  100, 0, -1, 0, -1);
    run_div("dz_neg",  -5, 0, -1, 0, -1);
    run_div("sat_pos", 134217727, 1, -1, 0, -1);
    run_div("sat_min", -134217728, -1, -1, 0, -1);
    run_div("edge_neg", -32768, 1, -1, 0, -1);
    run_div("zero_dvd", 0, -3, -1, 0, -1);
    run_div("dsr_min", 134217727, -2048, -1, 0, -1);

    // Stall mid-CALC.
    run_div("stall", 1000, 7, 12, 5, -1);

    // Done extended while ce is low.
    held = bus.dout;
    bus.ce = 1'b0;
    repeat (3) @(negedge clk);
    check("ce_hold_done", 64'(bus.done), 1);
    check("ce_hold_dout", 64'(bus.dout), 64'(held));
    bus.ce = 1'b1;
    @(negedge clk);
    check("ce_release_done", 64'(bus.done), 0);
    check("ce_release_dout", 64'(bus.dout), 64'(held));

    // Start while busy is ignored and not queued.
    run_div("ignored", 1000, 7, -1, 0, 5);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("no_second_done", 64'(n_done), 0);

    // Abort by reset mid-operation.
    bus.start = 1'b1;
    bus.din0  = 28'sd1000;
    bus.din1  = 12'sd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 0);
    check("abort_done", 64'(bus.done), 0);
    check("abort_dout", 64'(bus.dout), 0);
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("abort_no_done", 64'(n_done), 0);
    run_div("after_abort", 84, 12, -1, 0, -1);

    // Randomized operands with occasional stalls.
    for (int i = 0; i < 60; i++) begin
      ra  = 28'($urandom);
      rs  = 20'($urandom);
      rb  = 12'($urandom);
      rbs = 4'($urandom);
      a = ($urandom_range(0, 1) == 0) ? longint'(ra) : longint'(rs);
      case ($urandom_range(0, 7))
        0:       b = 0;
        1, 2, 3: b = longint'(rbs);
        default: b = longint'(rb);
      endcase
      if (b != 0 && $urandom_range(0, 3) == 0)
        run_div($sformatf("rnd%0d", i), a, b, int'($urandom_range(1, 20)), int'($urandom_range(1, 4)), -1);
      else
        run_div($sformatf("rnd%0d", i), a, b, -1, 0, -1);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reversi_accel_sdiv_seq_28s_12s_16.md
Name: reversi_accel_sdiv_seq_28s_12s_16

Overview:
- Iterative signed divider; the inverse of the accelerator's pipelined 16u×12s→28s multiplier.
- Recovers a board-evaluation weight (quotient) from an accumulated 28-bit signed score and a 12-bit signed scale factor.
- Restoring algorithm, one quotient bit per cycle, start/done handshake, ce stall like the other arithmetic cores.
- Sits beside the multiplier in the evaluation datapath.

Parameters:
- din0_WIDTH, 28, dividend width (signed); sets the iteration count.
- din1_WIDTH, 12, divisor width (signed); also the remainder width.
- dout_WIDTH, 16, quotient width (signed, saturating).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; sampled only in IDLE with ce=1.
- din0  in  din0_WIDTH  signed dividend, captured on accept.
- din1  in  din1_WIDTH  signed divisor, captured on accept.
- busy  out  1  high from the cycle after accept until done is asserted.
- done  out  1  one-cycle pulse; dout/rem/flags valid while high and held until next accept.
- dout  out  dout_WIDTH  signed quotient, truncated toward zero, saturated.
- rem  out  din1_WIDTH  signed remainder; sign follows dividend.
- div0  out  1  divisor was zero.
- ovf  out  1  quotient saturated because it does not fit in dout_WIDTH.

Behaviour:
- Reset: state IDLE; busy, done, dout, rem, div0, ovf all 0. Reset mid-operation aborts and discards the division; no done is produced.
- States:
  - IDLE: on ce & start, capture |din0| (din0_WIDTH bits, unsigned), |din1|, and both sign bits; clear partial remainder and counter; go to CALC.
  - CALC: each ce cycle, shift one dividend bit into the partial remainder (din1_WIDTH+1 bits); subtract |divisor| if it fits; shift the quotient bit into a din0_WIDTH-bit register. After din0_WIDTH iterations, go to FIX.
  - FIX: apply signs, saturate, register outputs, assert done for one cycle; go to IDLE.
- Latency: accept at edge 0 → done high after edge din0_WIDTH+1 (29 with defaults). Issue rate is one division per 30 cycles: start is accepted on the cycle done is high.
- start while busy is ignored and not queued.
- ce=0 freezes state, counter and outputs, including a high done, which is then extended.
- Sign rules:
  - Quotient is negative iff the signs differ and the magnitude is nonzero.
  - Remainder takes the dividend's sign; |rem| < |divisor| ≤ 2^(din1_WIDTH-1), so it always fits.
- Saturation: if the quotient magnitude exceeds 2^(dout_WIDTH-1)-1 (positive) or 2^(dout_WIDTH-1) (negative), dout = 32767 or -32768, ovf=1, rem still exact.
- Divide by zero:
  - Skips CALC; FIX is reached the cycle after accept, so done comes after edge 2.
  - dout = 32767 if din0 ≥ 0, else -32768; rem=0; div0=1; ovf=0.
- Most-negative dividend -2^27: the magnitude 2^27 is held in din0_WIDTH unsigned bits with no overflow.
- div0 and ovf are valid only with or after done and clear on the next accept.

Optional Feature:
- Macro: REVERSI_DIV_ROUND_EN.
- Defined: quotient rounds half away from zero. In FIX, if 2·|rem| ≥ |divisor|, the magnitude is incremented before sign and saturation, and rem becomes dividend − q·divisor (it may then have the opposite sign). Latency is unchanged.
- Undefined: truncation toward zero as above; no extra comparator is built.

Test Plan:
- din0=1000, din1=7, start pulse → done after edge 29; dout=142, rem=6, div0=0, ovf=0.
- din0=-1000, din1=7 → dout=-142, rem=-6. din0=1000, din1=-7 → dout=-142, rem=6. With REVERSI_DIV_ROUND_EN, din0=11, din1=2 → dout=6.
- din0=100, din1=0 → done after edge 2; dout=32767, div0=1, rem=0. din0=-5, din1=0 → dout=-32768.
- din0=134217727, din1=1 → dout=32767, ovf=1. din0=-134217728, din1=-1 → dout=32767, ovf=1. din0=-32768, din1=1 → dout=-32768, ovf=0.
- Stall and ignored start: ce low for 5 cycles mid-CALC → done delayed by exactly 5 cycles, result unchanged. start with din0=9 asserted while busy → ignored, first result delivered, no second done.
- Abort: reset at iteration 10 → next cycle busy=0, done=0, dout=0; a new 84/12 division then returns 7, rem 0.
